// File: rtl/datachk_pkg.sv
// datachk_pkg: shared types and constants for the AXI-Stream data checker.
//   state_t    - receive FSM encoding (IDLE / RECV / GAP / DONE)
//   DATA_W_DEF - default AXIS payload width
//   BEAT_W     - internal beat counter width; wide enough that frames longer
//                than 256 beats still compare correctly against frame_size
//   GAP_W      - inter-frame gap counter width (matches the 32-bit delay port)
package datachk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int BEAT_W     = 32;
  localparam int GAP_W      = 32;

endpackage

// File: rtl/datachk_capbuf_sdp.sv
// datachk_capbuf_sdp: simple dual-port capture RAM, DEPTH x DATA_W.
//   clk             - clock, rising edge
//   rst             - sync active-high; clears the read register only
//   wr_en/addr/data - single write port
//   rd_addr/rd_data - registered read port, 1-cycle latency.
// A read and a write to the same address in one cycle return the old data.
module datachk_capbuf_sdp #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 256,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;

  always_ff @(posedge clk)
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];

endmodule

// File: rtl/datachk.sv
// datachk: AXI-Stream slave that checks incrementing-counter frames.
//   clk, rst       - clock / sync active-high reset
//   en             - start reception (sampled in IDLE only)
//   clr            - sync clear of done, counters and FSM; blocks the beat
//   frame_size     - expected beats per frame, 0 disables the length check
//   delay          - tready-low cycles after each frame (inter-frame gap)
//   s_axis_*       - AXIS slave (tvalid/tready/tlast/tdata)
//   done           - frame received, held until clr
//   frame_cnt, data_err_cnt, len_err_cnt - saturating statistics
//   last_len       - beat count of the last frame, mod 256
//   rd_addr/rd_data - capture buffer readback, 1-cycle latency
module datachk
  import datachk_pkg::*;
#(
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int BUF_DEPTH = 256,
  parameter  int CNT_W     = 16,
  localparam int AW        = $clog2(BUF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [7:0]        frame_size,
  input  logic [31:0]       delay,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic [DATA_W-1:0] s_axis_tdata,
  output logic              done,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  data_err_cnt,
  output logic [CNT_W-1:0]  len_err_cnt,
  output logic [7:0]        last_len,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  state_t             state, state_nxt;
  logic               tready_q;
  logic [BEAT_W-1:0]  beat_idx, len_nxt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [DATA_W-1:0]  prev_q, pat_exp;
  logic               accept, last_acc, wr_en, len_bad, gap_done;

  // clr wins over a beat in the same cycle: ready is masked combinationally.
  assign s_axis_tready = tready_q & ~clr;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign last_acc      = accept & s_axis_tlast;

  assign len_nxt  = beat_idx + BEAT_W'(1);
  assign len_bad  = (frame_size != 8'd0) && (len_nxt != BEAT_W'(frame_size));
  assign pat_exp  = prev_q + DATA_W'(1);
  assign wr_en    = accept && (beat_idx < BEAT_W'(BUF_DEPTH));
  // >= rather than == so a delay lowered mid-gap cannot strand the FSM.
  assign gap_done = (gap_cnt + GAP_W'(1)) >= delay;

  // State register; tready is registered off the next state so it is high
  // exactly while the FSM sits in RECV.
  always_ff @(posedge clk)
    if (rst) begin
      state    <= ST_IDLE;
      tready_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      tready_q <= (state_nxt == ST_RECV);
    end

  always_comb begin
    state_nxt = state;
    if (clr) state_nxt = ST_IDLE;
    else begin
      case (state)
        ST_IDLE: if (en) state_nxt = ST_RECV;
        ST_RECV: if (last_acc) state_nxt = (delay != 32'd0) ? ST_GAP : ST_DONE;
        ST_GAP:  if (gap_done) state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_DONE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    done = (state == ST_DONE);
  end

  // Beat counter, pattern checker, gap counter and statistics.
  always_ff @(posedge clk)
    if (rst || clr) begin
      beat_idx     <= '0;
      prev_q       <= '0;
      gap_cnt      <= '0;
      frame_cnt    <= '0;
      data_err_cnt <= '0;
      len_err_cnt  <= '0;
      last_len     <= '0;
    end else begin
      gap_cnt <= (state == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
      if (accept) begin
        // Reference always follows the received value, so a mismatch
        // re-seeds and only the discontinuity itself is counted.
        prev_q <= s_axis_tdata;
        if (beat_idx != '0 && s_axis_tdata != pat_exp && !(&data_err_cnt))
          data_err_cnt <= data_err_cnt + CNT_W'(1);
        if (s_axis_tlast) begin
          beat_idx <= '0;
          last_len <= len_nxt[7:0];
          if (len_bad && !(&len_err_cnt)) len_err_cnt <= len_err_cnt + CNT_W'(1);
          if (!(&frame_cnt)) frame_cnt <= frame_cnt + CNT_W'(1);
        end else begin
          beat_idx <= len_nxt;
        end
      end
    end

  datachk_capbuf_sdp #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_capbuf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (beat_idx[AW-1:0]),
    .wr_data (s_axis_tdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_datachk.sv
// tb_datachk: table-driven frame vectors with a readback scoreboard, plus
// hand sequences for reset state, clr mid-frame and rst mid-frame.
module tb_datachk;

  localparam int BUF_DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst, en, clr;
  logic [7:0]  frame_size;
  logic [31:0] delay;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [7:0]  s_axis_tdata;
  logic        done;
  logic [15:0] frame_cnt, data_err_cnt, len_err_cnt;
  logic [7:0]  last_len, rd_addr, rd_data;

  int errors = 0;
  int checks = 0;

  logic [7:0] sb[$];

  typedef struct {
    int         n;
    logic [7:0] start;
    int         jidx;     // beat index where the pattern jumps
    logic [7:0] jval;     // value at the jump, increments from there
    logic [7:0] fsize;
    int         dly;
    int         vprob;    // tvalid probability in percent
    bit         en_drop;  // drop en after the first beat
    int         e_fc, e_de, e_le, e_ll;
  } vec_t;

  vec_t vecs[9];

  datachk #(.DATA_W(8), .BUF_DEPTH(BUF_DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .frame_size(frame_size), .delay(delay),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
    .done(done), .frame_cnt(frame_cnt), .data_err_cnt(data_err_cnt),
    .len_err_cnt(len_err_cnt), .last_len(last_len),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] bval(input vec_t v, input int i);
    if (i < v.jidx) return v.start + 8'(i);
    return v.jval + 8'(i - v.jidx);
  endfunction

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  // Called at #1 after a rising edge; returns at #1 after the last handshake.
  task automatic send_beats(input vec_t v, input int count, input bit with_last);
    int i = 0;
    int guard = 0;
    bit ok;
    while (i < count && guard < 4000) begin
      s_axis_tvalid = ($urandom_range(99) < v.vprob);
      s_axis_tdata  = bval(v, i);
      s_axis_tlast  = with_last && (i == count - 1);
      ok = s_axis_tvalid && s_axis_tready;
      @(posedge clk); #1;
      if (ok) begin
        if (i < BUF_DEPTH) sb.push_back(bval(v, i));
        if (i == 0 && v.en_drop) en = 1'b0;
        i++;
      end
      guard++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    chk("handshake_beats", i, count);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cnt;
    bit tr_bad;
    int nrd;
    sb.delete();
    frame_size = v.fsize;
    delay      = v.dly;
    en         = 1'b1;
    pulse_clr();
    send_beats(v, v.n, 1'b1);
    cnt = 0;
    tr_bad = 1'b0;
    while (!done && cnt < v.dly + 20) begin
      if (s_axis_tready) tr_bad = 1'b1;
      cnt++;
      @(posedge clk); #1;
    end
    chk({tag, ".gap_cycles"}, cnt, v.dly);
    repeat (3) begin
      if (s_axis_tready) tr_bad = 1'b1;
      @(posedge clk); #1;
    end
    chk({tag, ".tready_low"}, tr_bad, 0);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".frame_cnt"}, frame_cnt, v.e_fc);
    chk({tag, ".data_err"}, data_err_cnt, v.e_de);
    chk({tag, ".len_err"}, len_err_cnt, v.e_le);
    chk({tag, ".last_len"}, last_len, v.e_ll);
    nrd = sb.size();
    chk({tag, ".stored"}, nrd, (v.n < BUF_DEPTH) ? v.n : BUF_DEPTH);
    for (int a = 0; a < nrd; a++) begin
      rd_addr = 8'(a);
      @(posedge clk); #1;
      chk($sformatf("%s.rd%0d", tag, a), rd_data, sb.pop_front());
    end
  endtask

  initial begin
    vec_t v;
    //          n    start  jidx  jval   fsize dly vprob drop fc de le ll
    vecs[0] = '{10,  8'h00, 1000, 8'h00, 8'd10, 0, 100, 0,   1, 0, 0, 10};
    vecs[1] = '{4,   8'hFE, 1000, 8'h00, 8'd4,  0, 100, 0,   1, 0, 0, 4};
    vecs[2] = '{4,   8'h00, 2,    8'h05, 8'd4,  0, 100, 0,   1, 1, 0, 4};
    vecs[3] = '{7,   8'h20, 1000, 8'h00, 8'd4,  0, 100, 0,   1, 0, 1, 7};
    vecs[4] = '{10,  8'h00, 1000, 8'h00, 8'd10, 5, 100, 0,   1, 0, 0, 10};
    vecs[5] = '{10,  8'h00, 1000, 8'h00, 8'd10, 0, 50,  0,   1, 0, 0, 10};
    vecs[6] = '{3,   8'h70, 1000, 8'h00, 8'd0,  2, 100, 1,   1, 0, 0, 3};
    vecs[7] = '{300, 8'h00, 100,  8'h00, 8'd44, 0, 100, 0,   1, 1, 1, 44};
    vecs[8] = '{1,   8'hAA, 1000, 8'h00, 8'd1,  1, 100, 0,   1, 0, 0, 1};

    rst = 1'b1; en = 1'b0; clr = 1'b0; frame_size = 8'd0; delay = 32'd0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = 8'h00; rd_addr = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst.tready", s_axis_tready, 0);
    chk("rst.done", done, 0);
    chk("rst.frame_cnt", frame_cnt, 0);
    chk("rst.data_err", data_err_cnt, 0);
    chk("rst.len_err", len_err_cnt, 0);
    chk("rst.last_len", last_len, 0);
    chk("rst.rd_data", rd_data, 0);

    for (int k = 0; k < 9; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // clr mid-frame with a beat presented: ready masked, everything cleared.
    v = '{10, 8'h10, 2, 8'h20, 8'd0, 0, 100, 0, 0, 0, 0, 0};
    frame_size = 8'd0; delay = 32'd0; en = 1'b1;
    pulse_clr();
    send_beats(v, 3, 1'b0);
    chk("clr.pre_data_err", data_err_cnt, 1);
    s_axis_tvalid = 1'b1; s_axis_tdata = 8'h21; s_axis_tlast = 1'b1;
    clr = 1'b1;
    #1;
    chk("clr.tready_masked", s_axis_tready, 0);
    @(posedge clk); #1;
    clr = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    chk("clr.tready", s_axis_tready, 0);
    chk("clr.done", done, 0);
    chk("clr.frame_cnt", frame_cnt, 0);
    chk("clr.data_err", data_err_cnt, 0);
    chk("clr.last_len", last_len, 0);
    run_vec(vecs[0], "post_clr");

    // rst mid-frame: counters and read register return to reset values.
    v = '{10, 8'h33, 2, 8'h40, 8'd0, 0, 100, 0, 0, 0, 0, 0};
    en = 1'b1; rd_addr = 8'h00;
    pulse_clr();
    send_beats(v, 3, 1'b0);
    chk("rstmid.pre_data_err", data_err_cnt, 1);
    chk("rstmid.pre_rd_data", rd_data, 8'h33);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid.tready", s_axis_tready, 0);
    chk("rstmid.done", done, 0);
    chk("rstmid.frame_cnt", frame_cnt, 0);
    chk("rstmid.data_err", data_err_cnt, 0);
    chk("rstmid.len_err", len_err_cnt, 0);
    chk("rstmid.last_len", last_len, 0);
    chk("rstmid.rd_data", rd_data, 0);
    rst = 1'b0;
    run_vec(vecs[0], "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
